// File: rtl/decomposed_rca_core_if.sv
// Operand/result bundle for the pipelined ripple-carry adder.
// The producer side (master) drives operands and watches results;
// the adder (slave) consumes operands and drives results.
interface decomposed_rca_core_if #(
   parameter int NBIT = 16
);
   logic [NBIT-1:0] A;
   logic [NBIT-1:0] B;
   logic            VALID_I;
   logic [NBIT-1:0] S;
   logic            CO;
   logic            VALID_O;

   modport master (
      output A, B, VALID_I,
      input  S, CO, VALID_O
   );

   modport slave (
      input  A, B, VALID_I,
      output S, CO, VALID_O
   );
endinterface

// File: rtl/decomposed_rca_core.sv
// Pipelined ("decomposed") ripple-carry adder: S = A + B mod 2^NBIT.
// The carry chain is cut into NSTAGE segments of CHUNK bits with a register
// between segments, so the longest combinational path is one CHUNK-bit ripple.
// Operand slices are skewed on the way in and sum slices deskewed on the way
// out, so every result leaves NSTAGE cycles after its operands, in order.
module decomposed_rca_core #(
   parameter int NBIT  = 16,
   parameter int CHUNK = 4
) (
   input logic                   CLK,
   input logic                   RST,
   decomposed_rca_core_if.slave  bus
);
   localparam int NSTAGE = NBIT / CHUNK;

   // Carry registered at the end of each stage; the last one is CO.
   logic [NSTAGE-1:0] carry_q;
   // Deskewed sum bits, all aligned to the final stage.
   logic [NBIT-1:0]   s_out;
   // Valid bit travelling alongside the operand pair.
   logic [NSTAGE-1:0] valid_sr;

   for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
      localparam int DSK = NSTAGE - 1 - k;

      logic [CHUNK-1:0] a_in;
      logic [CHUNK-1:0] b_in;
      logic             c_in;
      logic [CHUNK-1:0] sum_c;
      logic             co_c;
      logic [CHUNK-1:0] sum_q;
      logic             co_q;

      if (k == 0) begin : g_first
         // Stage 0 sees the operands directly and has no carry-in.
         assign a_in = bus.A[CHUNK-1:0];
         assign b_in = bus.B[CHUNK-1:0];
         assign c_in = 1'b0;
      end else begin : g_skew
         logic [CHUNK-1:0] a_dly [k];
         logic [CHUNK-1:0] b_dly [k];

         // Delay slice k operands by k cycles so they meet the carry of their own pair.
         always_ff @(posedge CLK) begin
            if (RST) begin
               // NOTE: these are shift registers, not storage arrays, so clearing
               // every entry on reset is cheap and keeps the pipeline deterministic.
               for (int j = 0; j < k; j++) begin
                  a_dly[j] <= '0;
                  b_dly[j] <= '0;
               end
            end else begin
               a_dly[0] <= bus.A[k*CHUNK +: CHUNK];
               b_dly[0] <= bus.B[k*CHUNK +: CHUNK];
               for (int j = 1; j < k; j++) begin
                  a_dly[j] <= a_dly[j-1];
                  b_dly[j] <= b_dly[j-1];
               end
            end
         end

         assign a_in = a_dly[k-1];
         assign b_in = b_dly[k-1];
         assign c_in = carry_q[k-1];
      end

      // CHUNK-bit ripple of 1-bit full adders for this segment.
      always_comb begin
         logic rc;
         // NOTE: blocking assignments here are deliberate: rc must update bit by
         // bit inside the loop to model the ripple; sequential blocks use <= only.
         sum_c = '0;
         rc    = c_in;
         for (int i = 0; i < CHUNK; i++) begin
            sum_c[i] = a_in[i] ^ b_in[i] ^ rc;
            rc       = (a_in[i] & b_in[i]) | (rc & (a_in[i] ^ b_in[i]));
         end
         co_c = rc;
      end

      // Segment register: partial sum and carry handed to the next stage.
      always_ff @(posedge CLK) begin
         if (RST) begin
            sum_q <= '0;
            co_q  <= 1'b0;
         end else begin
            sum_q <= sum_c;
            co_q  <= co_c;
         end
      end

      assign carry_q[k] = co_q;

      if (DSK == 0) begin : g_nodeskew
         assign s_out[k*CHUNK +: CHUNK] = sum_q;
      end else begin : g_deskew
         logic [CHUNK-1:0] s_dly [DSK];

         // Hold early sum slices until the last stage has caught up.
         always_ff @(posedge CLK) begin
            if (RST) begin
               for (int j = 0; j < DSK; j++) begin
                  s_dly[j] <= '0;
               end
            end else begin
               s_dly[0] <= sum_q;
               for (int j = 1; j < DSK; j++) begin
                  s_dly[j] <= s_dly[j-1];
               end
            end
         end

         assign s_out[k*CHUNK +: CHUNK] = s_dly[DSK-1];
      end
   end

   // Valid shift register, NSTAGE deep; reset discards every in-flight pair.
   always_ff @(posedge CLK) begin
      if (RST) begin
         valid_sr <= '0;
      end else begin
         valid_sr[0] <= bus.VALID_I;
         for (int i = 1; i < NSTAGE; i++) begin
            valid_sr[i] <= valid_sr[i-1];
         end
      end
   end

   assign bus.S       = s_out;
   assign bus.CO      = carry_q[NSTAGE-1];
   assign bus.VALID_O = valid_sr[NSTAGE-1];
endmodule

// File: tb/tb_decomposed_rca_core.sv
// Self-checking bench for decomposed_rca_core (NBIT=16, CHUNK=4).
// Reference model: a latency queue of {valid, A+B} entries, NSTAGE long.
module tb_decomposed_rca_core;
   localparam int NBIT   = 16;
   localparam int CHUNK  = 4;
   localparam int NSTAGE = NBIT / CHUNK;

   typedef struct packed {
      logic            v;
      logic [NBIT:0]   sum;
   } exp_t;

   logic CLK;
   logic RST;
   int   n_cmp;
   int   n_bad;
   exp_t model_q[$];

   decomposed_rca_core_if #(.NBIT(NBIT)) bus ();

   decomposed_rca_core #(.NBIT(NBIT), .CHUNK(CHUNK)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Drive one cycle of stimulus, update the reference, return at the next negedge.
   task automatic cycle(input logic [NBIT-1:0] a, input logic [NBIT-1:0] b,
                        input logic v, input logic rst);
      exp_t e;
      bus.A       = a;
      bus.B       = b;
      bus.VALID_I = v;
      RST         = rst;
      @(posedge CLK);
      if (rst) begin
         model_q.delete();
         for (int i = 0; i < NSTAGE; i++) model_q.push_back('0);
      end else begin
         e.v   = v;
         e.sum = {1'b0, a} + {1'b0, b};
         model_q.push_back(e);
         while (model_q.size() > NSTAGE) void'(model_q.pop_front());
      end
      @(negedge CLK);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         cycle(16'hA5A5, 16'h5A5A, 1'b1, 1'b1);
         n_cmp++;
         if ({bus.VALID_O, bus.CO, bus.S} !== {1'b0, 1'b0, 16'h0000}) begin
            n_bad++;
            $display("FAIL reset_state: got v=%b co=%b s=%h want v=0 co=0 s=0000",
                     bus.VALID_O, bus.CO, bus.S);
         end
      end
      for (int i = 0; i < 6; i++) begin
         cycle(16'(i * 1234), 16'(i * 777), 1'b0, 1'b0);
         n_cmp++;
         if (bus.VALID_O !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle_valid: cycle %0d got v=%b want 0", i, bus.VALID_O);
         end
      end
   endtask

   task automatic test_stream();
      int sa [10] = '{0, 2, 2, 7, 7, 17, 17, 77, 77, 77};
      int sb [10] = '{0, 0, 3, 3, 8, 8, 58, 58, 118, 339};
      int ss [10] = '{0, 2, 5, 10, 15, 25, 75, 135, 195, 416};
      int got_n;
      int first_hit;
      got_n     = 0;
      first_hit = -1;
      for (int i = 0; i < 10 + NSTAGE; i++) begin
         if (i < 10) cycle(16'(sa[i]), 16'(sb[i]), 1'b1, 1'b0);
         else        cycle(16'h0, 16'h0, 1'b0, 1'b0);
         n_cmp++;
         if (bus.VALID_O !== model_q[0].v) begin
            n_bad++;
            $display("FAIL stream_valid: cycle %0d got %b want %b", i, bus.VALID_O, model_q[0].v);
         end
         if (bus.VALID_O === 1'b1) begin
            if (first_hit < 0) first_hit = i;
            if (got_n < 10) begin
               n_cmp++;
               if ({bus.CO, bus.S} !== 17'(ss[got_n])) begin
                  n_bad++;
                  $display("FAIL stream_sum[%0d]: got %0d want %0d", got_n, {bus.CO, bus.S}, ss[got_n]);
               end
            end
            got_n++;
         end
      end
      n_cmp++;
      if (got_n !== 10 || first_hit !== NSTAGE - 1) begin
         n_bad++;
         $display("FAIL stream_count: got %0d results from cycle %0d want 10 from cycle %0d",
                  got_n, first_hit, NSTAGE - 1);
      end
   endtask

   task automatic test_carry();
      logic [NBIT-1:0] ca [4] = '{16'h0FFF, 16'h7FFF, 16'hFFFF, 16'hFFFF};
      logic [NBIT-1:0] cb [4] = '{16'h0001, 16'h0001, 16'h0001, 16'hFFFF};
      logic [NBIT:0]   cs [4] = '{17'h01000, 17'h08000, 17'h10000, 17'h1FFFE};
      int got_n;
      got_n = 0;
      for (int i = 0; i < 4 + NSTAGE; i++) begin
         if (i < 4) cycle(ca[i], cb[i], 1'b1, 1'b0);
         else       cycle(16'h0, 16'h0, 1'b0, 1'b0);
         if (bus.VALID_O === 1'b1 && got_n < 4) begin
            n_cmp++;
            if ({bus.CO, bus.S} !== cs[got_n]) begin
               n_bad++;
               $display("FAIL carry_wrap[%0d]: got co=%b s=%h want %h", got_n, bus.CO, bus.S, cs[got_n]);
            end
            got_n++;
         end
      end
      n_cmp++;
      if (got_n !== 4) begin
         n_bad++;
         $display("FAIL carry_count: got %0d results want 4", got_n);
      end
   endtask

   task automatic test_reset_flight();
      int got_n;
      got_n = 0;
      for (int i = 0; i < 3; i++) cycle(16'(100 + i), 16'(200 + i), 1'b1, 1'b0);
      cycle(16'h1111, 16'h2222, 1'b1, 1'b1);
      for (int i = 0; i < NSTAGE + 1; i++) begin
         cycle(16'h0, 16'h0, 1'b0, 1'b0);
         n_cmp++;
         if (bus.VALID_O !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_valid: cycle %0d got %b want 0", i, bus.VALID_O);
         end
      end
      cycle(16'd5, 16'd6, 1'b1, 1'b0);
      for (int i = 1; i < NSTAGE + 2; i++) begin
         cycle(16'h0, 16'h0, 1'b0, 1'b0);
         n_cmp++;
         if (bus.VALID_O !== (i == NSTAGE - 1)) begin
            n_bad++;
            $display("FAIL post_reset_valid: %0d cycles after pair got %b want %b",
                     i, bus.VALID_O, (i == NSTAGE - 1));
         end
         if (bus.VALID_O === 1'b1) begin
            got_n++;
            n_cmp++;
            if ({bus.CO, bus.S} !== 17'd11) begin
               n_bad++;
               $display("FAIL post_reset_sum: got %0d want 11", {bus.CO, bus.S});
            end
         end
      end
      n_cmp++;
      if (got_n !== 1) begin
         n_bad++;
         $display("FAIL post_reset_count: got %0d results want 1", got_n);
      end
   endtask

   task automatic test_random();
      logic [31:0] ra;
      logic [31:0] rb;
      int          bad_here;
      bad_here = 0;
      for (int i = 0; i < 10000 + NSTAGE; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i < 10000) cycle(ra[NBIT-1:0], rb[NBIT-1:0], 1'($urandom_range(0, 3) != 0), 1'b0);
         else           cycle(16'h0, 16'h0, 1'b0, 1'b0);
         n_cmp++;
         if (bus.VALID_O !== model_q[0].v ||
             (model_q[0].v && {bus.CO, bus.S} !== model_q[0].sum)) begin
            n_bad++;
            bad_here++;
            if (bad_here <= 10)
               $display("FAIL random[%0d]: got v=%b sum=%h want v=%b sum=%h",
                        i, bus.VALID_O, {bus.CO, bus.S}, model_q[0].v, model_q[0].sum);
         end
      end
   endtask

   initial begin
      n_cmp       = 0;
      n_bad       = 0;
      RST         = 1'b1;
      bus.A       = '0;
      bus.B       = '0;
      bus.VALID_I = 1'b0;
      @(negedge CLK);
      test_reset();
      test_stream();
      test_carry();
      test_reset_flight();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
